// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select and load size.
package wb_pkg;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_LINK = 2'b10,
    SRC_IMM  = 2'b11
  } src_sel_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } ld_size_e;

  // Width of the byte offset within one register-file word.
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction, sign/zero extension and misalignment detect.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = off_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] ext_data,
  output logic              misalign
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;
  ld_size_e          size;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    size     = ld_size_e'(ld_size);
    shifted  = data >> {offset, 3'b000};
    mask     = '1;
    sign     = 1'b0;
    misalign = 1'b0;

    // A 32-bit register file has no dword loads; they behave as words.
    if (DATA_W == 32 && size == SZ_DWORD) size = SZ_WORD;

    case (size)
      SZ_BYTE: begin
        mask = DATA_W'(8'hFF);
        sign = shifted[7];
      end
      SZ_HALF: begin
        mask     = DATA_W'(16'hFFFF);
        sign     = shifted[15];
        misalign = offset[0];
      end
      SZ_WORD: begin
        mask     = DATA_W'(32'hFFFF_FFFF);
        sign     = shifted[31];
        misalign = |offset[1:0];
      end
      default: begin
        mask     = '1;
        sign     = shifted[DATA_W-1];
        misalign = |offset;
      end
    endcase

    ext_data = (shifted & mask) | ((sign && !ld_unsigned) ? ~mask : '0);
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback pipeline register: result select, load alignment, write gating and retire count.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [1:0]         src_sel,
  input  logic [1:0]         ld_size,
  input  logic               ld_unsigned,
  input  logic               reg_write,
  input  logic [RADDR_W-1:0] waddr_in,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  read_data_mem,
  input  logic [DATA_W-1:0]  pc_adder,
  input  logic [DATA_W-1:0]  imm_value,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RADDR_W-1:0] wb_addr,
  output logic               wb_we,
  output logic               misalign,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam int OFF_W = off_w(DATA_W);

  logic [DATA_W-1:0] load_data;
  logic              load_misalign;
  logic [DATA_W-1:0] sel_data;
  logic              sel_misalign;
  logic              sel_we;

  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .data        (read_data_mem),
    .offset      (alu_result[OFF_W-1:0]),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .ext_data    (load_data),
    .misalign    (load_misalign)
  );

  always_comb begin
    sel_data     = alu_result;
    sel_misalign = 1'b0;
    case (src_sel_e'(src_sel))
      SRC_MEM: begin
        sel_data     = load_data;
        sel_misalign = load_misalign;
      end
      SRC_LINK: sel_data = pc_adder;
      SRC_IMM:  sel_data = imm_value;
      default:  sel_data = alu_result;
    endcase
    // Register 0 is hard-wired; a misaligned load is reported but never written.
    sel_we = in_valid && reg_write && (|waddr_in) && !sel_misalign;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_data    <= '0;
      wb_addr    <= '0;
      wb_we      <= 1'b0;
      misalign   <= 1'b0;
      retire_cnt <= '0;
    end else if (flush) begin
      wb_we    <= 1'b0;
      misalign <= 1'b0;
    end else if (!stall) begin
      wb_data  <= sel_data;
      wb_addr  <= waddr_in;
      wb_we    <= sel_we;
      misalign <= in_valid && sel_misalign;
      if (in_valid) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage at DATA_W=32 and DATA_W=64.
module tb_writeback_stage;
  import wb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // 32-bit instance signals
  logic        rst_a = 1'b0, valid_a = 1'b0, stall_a = 1'b0, flush_a = 1'b0;
  logic [1:0]  src_a = 2'b00, size_a = 2'b00;
  logic        uns_a = 1'b0, rw_a = 1'b0;
  logic [4:0]  waddr_a = '0;
  logic [31:0] alu_a = '0, mem_a = '0, pc_a = '0, imm_a = '0;
  logic [31:0] data_a;
  logic [4:0]  addr_a;
  logic        we_a, mis_a;
  logic [31:0] cnt_a;

  // 64-bit instance signals with a short retire counter
  logic        rst_b = 1'b0, valid_b = 1'b0, stall_b = 1'b0, flush_b = 1'b0;
  logic [1:0]  src_b = 2'b00, size_b = 2'b00;
  logic        uns_b = 1'b0, rw_b = 1'b0;
  logic [4:0]  waddr_b = '0;
  logic [63:0] alu_b = '0, mem_b = '0, pc_b = '0, imm_b = '0;
  logic [63:0] data_b;
  logic [4:0]  addr_b;
  logic        we_b, mis_b;
  logic [3:0]  cnt_b;

  writeback_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(valid_a), .stall(stall_a), .flush(flush_a),
    .src_sel(src_a), .ld_size(size_a), .ld_unsigned(uns_a), .reg_write(rw_a),
    .waddr_in(waddr_a), .alu_result(alu_a), .read_data_mem(mem_a),
    .pc_adder(pc_a), .imm_value(imm_a), .wb_data(data_a), .wb_addr(addr_a),
    .wb_we(we_a), .misalign(mis_a), .retire_cnt(cnt_a)
  );

  writeback_stage #(.DATA_W(64), .RADDR_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(valid_b), .stall(stall_b), .flush(flush_b),
    .src_sel(src_b), .ld_size(size_b), .ld_unsigned(uns_b), .reg_write(rw_b),
    .waddr_in(waddr_b), .alu_result(alu_b), .read_data_mem(mem_b),
    .pc_adder(pc_b), .imm_value(imm_b), .wb_data(data_b), .wb_addr(addr_b),
    .wb_we(we_b), .misalign(mis_b), .retire_cnt(cnt_b)
  );

  typedef struct {
    logic        valid, stall, flush;
    logic [1:0]  src, size;
    logic        uns, rw;
    logic [4:0]  waddr;
    logic [31:0] alu, mem, pc, imm;
    logic        chk_data;
    logic [31:0] e_data;
    logic [4:0]  e_addr;
    logic        e_we, e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic valid, input logic [1:0] src, input logic [1:0] size, input logic uns,
    input logic rw, input logic [4:0] waddr, input logic [31:0] alu, input logic [31:0] mem,
    input logic [31:0] pc, input logic [31:0] imm, input logic chk,
    input logic [31:0] e_data, input logic e_we, input logic e_mis, input logic [31:0] e_cnt);
    vec_t v;
    v.valid = valid; v.stall = 1'b0; v.flush = 1'b0;
    v.src = src; v.size = size; v.uns = uns; v.rw = rw; v.waddr = waddr;
    v.alu = alu; v.mem = mem; v.pc = pc; v.imm = imm;
    v.chk_data = chk; v.e_data = e_data; v.e_addr = waddr;
    v.e_we = e_we; v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive_a(input vec_t v);
    valid_a = v.valid; stall_a = v.stall; flush_a = v.flush;
    src_a = v.src; size_a = v.size; uns_a = v.uns; rw_a = v.rw;
    waddr_a = v.waddr; alu_a = v.alu; mem_a = v.mem; pc_a = v.pc; imm_a = v.imm;
  endtask

  task automatic expect_a(input string tag, input logic chk, input logic [31:0] d,
                          input logic [4:0] a, input logic we, input logic mis,
                          input logic [31:0] cnt);
    if (chk) begin
      check({tag, ".data"}, 64'(data_a), 64'(d));
      check({tag, ".addr"}, 64'(addr_a), 64'(a));
    end
    check({tag, ".we"},  64'(we_a),  64'(we));
    check({tag, ".mis"}, 64'(mis_a), 64'(mis));
    check({tag, ".cnt"}, 64'(cnt_a), 64'(cnt));
  endtask

  task automatic expect_b(input string tag, input logic chk, input logic [63:0] d,
                          input logic we, input logic mis, input logic [3:0] cnt);
    if (chk) check({tag, ".data"}, data_b, d);
    check({tag, ".we"},  64'(we_b),  64'(we));
    check({tag, ".mis"}, 64'(mis_b), 64'(mis));
    check({tag, ".cnt"}, 64'(cnt_b), 64'(cnt));
  endtask

  task automatic load_b(input logic [1:0] src, input logic [1:0] size, input logic uns,
                        input logic [63:0] alu, input logic [63:0] mem);
    valid_b = 1'b1; rw_b = 1'b1; waddr_b = 5'd2;
    src_b = src; size_b = size; uns_b = uns; alu_b = alu; mem_b = mem;
  endtask

  localparam logic [31:0] PC = 32'h1111_0000;
  localparam logic [31:0] IM = 32'h2222_0000;
  localparam logic [31:0] MM = 32'h3333_4444;

  initial begin
    vec_t v;
    //            vld src    size   uns  rw  waddr  alu           mem           pc  imm chk e_data        we  mis cnt
    vecs.push_back(mk(1, 2'd0, 2'd0, 0, 1, 5'd5,  32'h1234_5678, MM,           PC, IM, 1, 32'h1234_5678, 1, 0, 1));
    vecs.push_back(mk(1, 2'd1, 2'd0, 0, 1, 5'd7,  32'h0000_0003, 32'h80FF_0000, PC, IM, 1, 32'hFFFF_FF80, 1, 0, 2));
    vecs.push_back(mk(1, 2'd1, 2'd1, 1, 1, 5'd8,  32'h0000_0001, 32'hAABB_CCDD, PC, IM, 0, 32'h0,         0, 1, 3));
    vecs.push_back(mk(1, 2'd2, 2'd0, 0, 1, 5'd31, 32'h0000_0000, MM,  32'h48,      IM, 1, 32'h0000_0048, 1, 0, 4));
    vecs.push_back(mk(1, 2'd3, 2'd0, 0, 1, 5'd0,  32'h0000_0000, MM,  PC, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0, 0, 5));
    vecs.push_back(mk(1, 2'd1, 2'd1, 0, 1, 5'd9,  32'h0000_0002, 32'h8001_1234, PC, IM, 1, 32'hFFFF_8001, 1, 0, 6));
    vecs.push_back(mk(1, 2'd1, 2'd0, 1, 1, 5'd10, 32'h0000_0001, 32'h0000_F500, PC, IM, 1, 32'h0000_00F5, 1, 0, 7));
    vecs.push_back(mk(1, 2'd1, 2'd3, 0, 1, 5'd11, 32'h0000_0000, 32'h8765_4321, PC, IM, 1, 32'h8765_4321, 1, 0, 8));
    vecs.push_back(mk(1, 2'd1, 2'd3, 0, 1, 5'd11, 32'h0000_0002, 32'h8765_4321, PC, IM, 0, 32'h0,         0, 1, 9));
    vecs.push_back(mk(0, 2'd0, 2'd0, 0, 1, 5'd3,  32'h0000_0077, MM,           PC, IM, 0, 32'h0,         0, 0, 9));
    vecs.push_back(mk(1, 2'd0, 2'd1, 1, 1, 5'd4,  32'h0000_0001, MM,           PC, IM, 1, 32'h0000_0001, 1, 0, 10));
    vecs.push_back(mk(1, 2'd0, 2'd0, 0, 0, 5'd6,  32'h0000_0055, MM,           PC, IM, 1, 32'h0000_0055, 0, 0, 11));
    vecs.push_back(mk(1, 2'd1, 2'd2, 0, 1, 5'd13, 32'h0000_0104, 32'h7FFF_0000, PC, IM, 1, 32'h7FFF_0000, 1, 0, 12));
    vecs.push_back(mk(1, 2'd1, 2'd0, 0, 1, 5'd14, 32'h0000_0002, 32'h007F_0000, PC, IM, 1, 32'h0000_007F, 1, 0, 13));

    // Reset state of both instances
    rst_a = 1'b0; rst_b = 1'b0;
    valid_a = 1'b1; rw_a = 1'b1; waddr_a = 5'd9; alu_a = 32'hFFFF_FFFF;
    step(); step();
    expect_a("reset", 1, 32'h0, 5'd0, 0, 0, 0);
    expect_b("reset_b", 1, 64'h0, 0, 0, 4'd0);

    // Table-driven main function, 32-bit instance
    rst_a = 1'b1;
    foreach (vecs[i]) begin
      drive_a(vecs[i]);
      step();
      expect_a($sformatf("v%0d", i), vecs[i].chk_data, vecs[i].e_data, vecs[i].e_addr,
               vecs[i].e_we, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // Stall holds everything while inputs keep changing
    v = mk(1, 2'd0, 2'd0, 0, 1, 5'd12, 32'hCAFE_0001, MM, PC, IM, 1, 32'hCAFE_0001, 1, 0, 14);
    drive_a(v);
    step();
    expect_a("stall_pre", 1, 32'hCAFE_0001, 5'd12, 1, 0, 14);
    for (int k = 0; k < 3; k++) begin
      v = mk(1, 2'(k + 1), 2'd1, 1, 1, 5'(20 + k), 32'h1 + 32'(k), 32'h9999_0000 + 32'(k),
             32'h40 + 32'(k), 32'h50 + 32'(k), 0, 32'h0, 0, 0, 0);
      v.stall = 1'b1;
      drive_a(v);
      step();
      expect_a($sformatf("stall%0d", k), 1, 32'hCAFE_0001, 5'd12, 1, 0, 14);
    end

    // Flush beats a simultaneous stall and does not retire
    v.flush = 1'b1; v.stall = 1'b1; v.src = 2'd0;
    drive_a(v);
    step();
    expect_a("flush_stall", 0, 32'h0, 5'd0, 0, 0, 14);

    // Misaligned load, then flush clears the flag
    v = mk(1, 2'd1, 2'd1, 0, 1, 5'd15, 32'h0000_0003, MM, PC, IM, 0, 32'h0, 0, 1, 15);
    drive_a(v);
    step();
    expect_a("mis_pre", 0, 32'h0, 5'd0, 0, 1, 15);
    v.flush = 1'b1;
    drive_a(v);
    step();
    expect_a("flush_mis", 0, 32'h0, 5'd0, 0, 0, 15);

    // Reset mid-stream drops the in-flight result; first output afterwards comes from rst=1 input
    v = mk(1, 2'd0, 2'd0, 0, 1, 5'd16, 32'h0BAD_0BAD, MM, PC, IM, 1, 32'h0, 0, 0, 0);
    drive_a(v);
    rst_a = 1'b0;
    step();
    expect_a("rst_mid", 1, 32'h0, 5'd0, 0, 0, 0);
    v = mk(1, 2'd2, 2'd0, 0, 1, 5'd17, 32'h0, MM, 32'h0000_0100, IM, 1, 32'h0000_0100, 1, 0, 1);
    drive_a(v);
    rst_a = 1'b1;
    step();
    expect_a("post_rst", 1, 32'h0000_0100, 5'd17, 1, 0, 1);
    valid_a = 1'b0;

    // 64-bit instance: dword load, sub-word loads, dword misalign
    rst_b = 1'b1;
    pc_b = 64'h1111_2222_3333_4444; imm_b = 64'h5555_6666_7777_8888;
    load_b(2'd1, 2'd3, 0, 64'h0, 64'hFEDC_BA98_7654_3210);
    step();
    expect_b("b_dword", 1, 64'hFEDC_BA98_7654_3210, 1, 0, 4'd1);
    load_b(2'd1, 2'd0, 0, 64'h7, 64'h8000_0000_0000_0000);
    step();
    expect_b("b_byte7", 1, 64'hFFFF_FFFF_FFFF_FF80, 1, 0, 4'd2);
    load_b(2'd1, 2'd2, 1, 64'h4, 64'h8765_4321_0000_0000);
    step();
    expect_b("b_wordu", 1, 64'h0000_0000_8765_4321, 1, 0, 4'd3);
    load_b(2'd1, 2'd2, 0, 64'h4, 64'h8765_4321_0000_0000);
    step();
    expect_b("b_words", 1, 64'hFFFF_FFFF_8765_4321, 1, 0, 4'd4);
    load_b(2'd1, 2'd3, 0, 64'h4, 64'h8765_4321_0000_0000);
    step();
    expect_b("b_dmis", 0, 64'h0, 0, 1, 4'd5);

    // Retire counter wraps at 2^CNT_W
    load_b(2'd0, 2'd0, 0, 64'h0123_4567_89AB_CDEF, 64'h0);
    for (int k = 0; k < 10; k++) step();
    expect_b("b_cnt_max", 1, 64'h0123_4567_89AB_CDEF, 1, 0, 4'd15);
    rw_b = 1'b0;
    step();
    expect_b("b_cnt_wrap", 1, 64'h0123_4567_89AB_CDEF, 0, 0, 4'd0);

    // Reset mid-stream on the 64-bit instance
    rw_b = 1'b1;
    step();
    rst_b = 1'b0;
    step();
    expect_b("b_rst_mid", 1, 64'h0, 0, 0, 4'd0);
    check("b_rst_addr", 64'(addr_b), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
